// File: rtl/snake_pkg.sv
// Shared types for the snake game core: direction encoding, game state
// and the helper that maps a direction to its reverse.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_R = 2'd0,
        DIR_L = 2'd1,
        DIR_U = 2'd2,
        DIR_D = 2'd3
    } dir_t;

    typedef enum logic {
        RUN  = 1'b0,
        OVER = 1'b1
    } state_t;

    // Reverse of a direction; used to reject 180-degree turns.
    function automatic dir_t opposite(input dir_t d);
        case (d)
            DIR_R:   opposite = DIR_L;
            DIR_L:   opposite = DIR_R;
            DIR_U:   opposite = DIR_D;
            DIR_D:   opposite = DIR_U;
            default: opposite = DIR_R;
        endcase
    endfunction

endpackage

// File: rtl/snake_dir_queue.sv
// Two-entry filtered direction FIFO. New requests are compared against the
// most recently queued direction (or the live one when empty); repeats and
// reversals are discarded, and a push into a full queue is dropped.
// Each pop retires the oldest entry into the live direction.
module snake_dir_queue
    import snake_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_srst,
    input  logic i_run,
    input  logic i_push,
    input  dir_t i_dir,
    input  logic i_pop,
    output dir_t o_next_dir
);

    dir_t       r_cur_dir;
    dir_t       r_q0;
    dir_t       r_q1;
    dir_t       w_last;
    logic [1:0] r_count;
    logic       w_push_ok;
    logic       w_pop_ok;

    // Direction a new request is filtered against: queue tail, or live direction when empty.
    always_comb begin
        w_last = r_cur_dir;
        case (r_count)
            2'd0:    w_last = r_cur_dir;
            2'd1:    w_last = r_q0;
            2'd2:    w_last = r_q1;
            default: w_last = r_cur_dir;
        endcase
    end

    assign w_push_ok  = i_run && i_push && (r_count != 2'd2) &&
                        (i_dir != w_last) && (i_dir != opposite(w_last));
    assign w_pop_ok   = i_pop && (r_count != 2'd0);
    // Direction the next move will use: the entry about to be popped, if any.
    assign o_next_dir = (r_count != 2'd0) ? r_q0 : r_cur_dir;

    // Queue storage and live direction; push and pop may happen in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_dir <= DIR_R;
            r_q0      <= DIR_R;
            r_q1      <= DIR_R;
            r_count   <= 2'd0;
        end else if (i_srst) begin
            r_cur_dir <= DIR_R;
            r_q0      <= DIR_R;
            r_q1      <= DIR_R;
            r_count   <= 2'd0;
        end else begin
            if (w_pop_ok) begin
                r_cur_dir <= r_q0;
            end else begin
                r_cur_dir <= r_cur_dir;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_q0 <= i_dir;
                    end else begin
                        r_q1 <= i_dir;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_q0    <= r_q1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Push is only accepted when not full, so one entry leaves and one arrives.
                    r_q0 <= (r_count == 2'd1) ? i_dir : r_q1;
                    r_q1 <= i_dir;
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

endmodule

// File: rtl/snake_engine.sv
// Snake game core. A fixed-rate tick moves the head one cell, shifts the
// body along a flat segment register chain, grows on food, and ends the
// game on self or wall collision. A combinational per-cell query serves
// the pixel renderer. restart reinitialises everything and wins over any
// other event in the same cycle.
module snake_engine
    import snake_pkg::*;
#(
    parameter int MAX_LEN  = 16,
    parameter int GRID_W   = 80,
    parameter int GRID_H   = 60,
    parameter int CW       = 7,
    parameter int TICK_DIV = 312500,
    parameter int WRAP     = 1,
    parameter int INIT_X   = 40,
    parameter int INIT_Y   = 30
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          restart,
    input  logic          dir_valid,
    input  logic [1:0]    dir,
    input  logic [CW-1:0] food_x,
    input  logic [CW-1:0] food_y,
    input  logic [CW-1:0] qry_x,
    input  logic [CW-1:0] qry_y,
    output logic          qry_hit,
    output logic          eat,
    output logic [CW-1:0] head_x,
    output logic [CW-1:0] head_y,
    output logic [6:0]    length,
    output logic          game_over
);

    localparam int            CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [CW-1:0] X_MAX   = CW'(GRID_W - 1);
    localparam logic [CW-1:0] Y_MAX   = CW'(GRID_H - 1);
    localparam logic [CW-1:0] X_INIT  = CW'(INIT_X);
    localparam logic [CW-1:0] Y_INIT  = CW'(INIT_Y);
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [6:0]    LEN_MAX = 7'(MAX_LEN);

    logic [CNT_W-1:0] r_cnt;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [6:0]       r_len;
    logic [6:0]       w_len_nxt;
    logic             r_eat;
    logic             w_eat_nxt;
    logic             w_tick;
    logic             w_off_grid;
    logic             w_self_hit;
    logic             w_hit_food;
    logic             w_advance;
    dir_t             w_move_dir;
    logic [CW-1:0]    w_nh_x;
    logic [CW-1:0]    w_nh_y;
    logic [CW-1:0]    w_seg_x [MAX_LEN];
    logic [CW-1:0]    w_seg_y [MAX_LEN];
    logic [MAX_LEN-1:0] w_qry_match;
    logic [MAX_LEN-1:0] w_col_match;

    assign w_tick = (r_state == RUN) && (r_cnt == CNT_MAX);

    // Move-tick divider; parked at zero while the game is over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (restart) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if ((r_state == OVER) || w_tick) begin
            r_cnt <= {CNT_W{1'b0}};
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    snake_dir_queue u_dir_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_srst     (restart),
        .i_run      (r_state == RUN),
        .i_push     (dir_valid),
        .i_dir      (dir_t'(dir)),
        .i_pop      (w_tick),
        .o_next_dir (w_move_dir)
    );

    // Candidate head cell one step along the move direction, with edge wrap or wall detection.
    always_comb begin
        w_nh_x     = w_seg_x[0];
        w_nh_y     = w_seg_y[0];
        w_off_grid = 1'b0;
        case (w_move_dir)
            DIR_R: begin
                if (w_seg_x[0] == X_MAX) begin
                    if (WRAP != 0) w_nh_x = {CW{1'b0}};
                    else           w_off_grid = 1'b1;
                end else begin
                    w_nh_x = w_seg_x[0] + ONE;
                end
            end
            DIR_L: begin
                if (w_seg_x[0] == {CW{1'b0}}) begin
                    if (WRAP != 0) w_nh_x = X_MAX;
                    else           w_off_grid = 1'b1;
                end else begin
                    w_nh_x = w_seg_x[0] - ONE;
                end
            end
            DIR_U: begin
                if (w_seg_y[0] == {CW{1'b0}}) begin
                    if (WRAP != 0) w_nh_y = Y_MAX;
                    else           w_off_grid = 1'b1;
                end else begin
                    w_nh_y = w_seg_y[0] - ONE;
                end
            end
            DIR_D: begin
                if (w_seg_y[0] == Y_MAX) begin
                    if (WRAP != 0) w_nh_y = {CW{1'b0}};
                    else           w_off_grid = 1'b1;
                end else begin
                    w_nh_y = w_seg_y[0] + ONE;
                end
            end
            default: begin
                w_off_grid = 1'b0;
            end
        endcase
    end

    // The tail (index length-1) is excluded from collision because it vacates on this move.
    assign w_self_hit = |w_col_match;
    assign w_hit_food = (w_nh_x == food_x) && (w_nh_y == food_y);
    assign w_advance  = w_tick && !w_off_grid && !w_self_hit;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_seg
            localparam logic [CW-1:0] RST_X = (gi == 0) ? X_INIT : {CW{1'b0}};
            localparam logic [CW-1:0] RST_Y = (gi == 0) ? Y_INIT : {CW{1'b0}};
            logic [CW-1:0] r_x;
            logic [CW-1:0] r_y;
            logic [CW-1:0] w_src_x;
            logic [CW-1:0] w_src_y;

            if (gi == 0) begin : g_head
                assign w_src_x = w_nh_x;
                assign w_src_y = w_nh_y;
            end else begin : g_body
                assign w_src_x = w_seg_x[gi-1];
                assign w_src_y = w_seg_y[gi-1];
            end

            // Segment cell: reloads on restart, takes its predecessor's cell on every legal move.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_x <= RST_X;
                    r_y <= RST_Y;
                end else if (restart) begin
                    r_x <= RST_X;
                    r_y <= RST_Y;
                end else if (w_advance) begin
                    r_x <= w_src_x;
                    r_y <= w_src_y;
                end else begin
                    r_x <= r_x;
                    r_y <= r_y;
                end
            end

            assign w_seg_x[gi]     = r_x;
            assign w_seg_y[gi]     = r_y;
            assign w_qry_match[gi] = (7'(gi) < r_len) && (r_x == qry_x) && (r_y == qry_y);
            assign w_col_match[gi] = ((7'(gi) + 7'd2) <= r_len) &&
                                     (r_x == w_nh_x) && (r_y == w_nh_y);
        end
    endgenerate

    // Next state, length growth and eat pulse for the current cycle; collision beats eating.
    always_comb begin
        w_state_nxt = r_state;
        w_eat_nxt   = 1'b0;
        w_len_nxt   = r_len;
        case (r_state)
            RUN: begin
                if (w_tick && (w_off_grid || w_self_hit)) begin
                    w_state_nxt = OVER;
                end else begin
                    w_state_nxt = RUN;
                end
                if (w_advance && w_hit_food) begin
                    w_eat_nxt = 1'b1;
                    if (r_len < LEN_MAX) begin
                        w_len_nxt = r_len + 7'd1;
                    end else begin
                        w_len_nxt = r_len;
                    end
                end else begin
                    w_eat_nxt = 1'b0;
                end
            end
            OVER: begin
                w_state_nxt = OVER;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    // Game state, length and eat pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_len   <= 7'd1;
            r_eat   <= 1'b0;
        end else if (restart) begin
            r_state <= RUN;
            r_len   <= 7'd1;
            r_eat   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_len   <= w_len_nxt;
            r_eat   <= w_eat_nxt;
        end
    end

    assign qry_hit   = |w_qry_match;
    assign eat       = r_eat;
    assign head_x    = w_seg_x[0];
    assign head_y    = w_seg_y[0];
    assign length    = r_len;
    assign game_over = (r_state == OVER);

endmodule
